// File: rtl/cordic_lin_div.sv
// Linear-vectoring CORDIC divider: drives y toward zero by adding or subtracting
// shifted copies of x, and accumulates the matching powers of two in z.
module cordic_lin_div #(
   parameter int WIDTH = 15,
   parameter int FRAC  = 12,
   parameter int ITER  = 13
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH:0]   y_in,
   input  logic [WIDTH:0]   x_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   q_out,
   output logic             div_err
);

   localparam int YW = WIDTH + 3;
   localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   localparam logic [WIDTH+1:0] UNIT  = (WIDTH+2)'(1) << FRAC;
   localparam logic [WIDTH:0]   ZMAX  = {1'b0, {WIDTH{1'b1}}};
   localparam logic [WIDTH:0]   ZMIN  = {1'b1, {WIDTH{1'b0}}};
   localparam logic [IW-1:0]    ILAST = IW'(ITER - 1);

   logic [1:0]             state;
   logic signed [YW-1:0]   xReg;
   logic signed [YW-1:0]   yReg;
   logic [WIDTH:0]         zReg;
   logic [IW-1:0]          iter;

   logic signed [YW-1:0]   xShift;
   logic signed [YW-1:0]   yNext;
   logic [WIDTH+1:0]       step;
   logic [WIDTH+1:0]       zSum;
   logic [WIDTH:0]         zNext;
   logic                   dPos;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == HOLD);

   // One micro-iteration: direction follows whether y and x agree in sign; the
   // z sum carries one guard bit so overflow can be detected and clamped.
   always_comb begin
      xShift = xReg >>> iter;
      step   = UNIT >> iter;
      dPos   = (yReg == '0) || (yReg[YW-1] == xReg[YW-1]);
      yNext  = dPos ? (yReg - xShift) : (yReg + xShift);
      zSum   = dPos ? ({zReg[WIDTH], zReg} + step) : ({zReg[WIDTH], zReg} - step);
      zNext  = zSum[WIDTH:0];
      if (zSum[WIDTH+1] != zSum[WIDTH]) begin
         zNext = zSum[WIDTH+1] ? ZMIN : ZMAX;
      end
   end

   // Control and datapath state; a zero divisor skips iteration entirely and
   // the result register is written only on the final iteration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         xReg    <= '0;
         yReg    <= '0;
         zReg    <= '0;
         iter    <= '0;
         q_out   <= '0;
         div_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (x_in == '0) begin
                     q_out   <= '0;
                     div_err <= 1'b1;
                     state   <= HOLD;
                  end else begin
                     xReg    <= {{2{x_in[WIDTH]}}, x_in};
                     yReg    <= {{2{y_in[WIDTH]}}, y_in};
                     zReg    <= '0;
                     iter    <= '0;
                     div_err <= 1'b0;
                     state   <= CALC;
                  end
               end
            end
            CALC: begin
               yReg <= yNext;
               zReg <= zNext;
               if (iter == ILAST) begin
                  q_out   <= zNext;
                  div_err <= 1'b0;
                  state   <= HOLD;
               end else begin
                  iter <= iter + 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_lin_div.sv
// Directed and swept checks of cordic_lin_div quotient, error flag, latency,
// output hold behaviour and asynchronous reset abort.
module tb_cordic_lin_div;

   localparam int WIDTH = 15;
   localparam int FRAC  = 12;
   localparam int ITER  = 13;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WIDTH:0]    y_in = '0;
   logic [WIDTH:0]    x_in = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [WIDTH:0]    q_out;
   logic              div_err;

   int numVectors = 0;
   int numMiscompares = 0;

   cordic_lin_div #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER(ITER)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .y_in(y_in),
      .x_in(x_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .q_out(q_out),
      .div_err(div_err)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expected value within a tolerance.
   task automatic checkOutput(input string tag, input int obs, input int exp, input int tol);
      numVectors++;
      if ((obs - exp > tol) || (exp - obs > tol)) begin
         numMiscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   // Offer one pair, then count cycles until out_valid; lat is 1 when the result
   // appears in the cycle right after the acceptance edge.
   task automatic applyStimulus(input logic [WIDTH:0] y, input logic [WIDTH:0] x,
                                output int lat, output int q, output int err);
      @(negedge clk);
      checkOutput("in_ready_before_accept", int'(in_ready), 1, 0);
      y_in = y;
      x_in = x;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      q = int'($signed(q_out));
      err = int'(div_err);
      if (out_ready) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int q;
      int err;
      int q0;
      int seen;
      int kv;
      int xs;
      int lim;
      int ys;
      int expq;

      repeat (2) @(negedge clk);
      checkOutput("reset_in_ready", int'(in_ready), 1, 0);
      checkOutput("reset_out_valid", int'(out_valid), 0, 0);
      checkOutput("reset_q_out", int'(q_out), 0, 0);
      checkOutput("reset_div_err", int'(div_err), 0, 0);
      rst_n = 1'b1;

      applyStimulus(16'h0800, 16'h1000, lat, q, err);
      checkOutput("half_latency", lat, ITER + 1, 0);
      checkOutput("half_q", q, 2048, 2);
      checkOutput("half_err", err, 0, 0);

      applyStimulus(16'h1000, 16'h0C00, lat, q, err);
      checkOutput("four_thirds_q", q, 5461, 2);
      checkOutput("four_thirds_latency", lat, ITER + 1, 0);

      applyStimulus(16'hF400, 16'h1000, lat, q, err);
      checkOutput("neg_three_quarter_q", q, -3072, 2);
      checkOutput("neg_three_quarter_err", err, 0, 0);

      applyStimulus(16'h0800, 16'hF000, lat, q, err);
      checkOutput("neg_divisor_q", q, -2048, 2);

      applyStimulus(16'h4000, 16'h1000, lat, q, err);
      checkOutput("out_of_range_q", q, 8191, 0);
      checkOutput("out_of_range_err", err, 0, 0);

      applyStimulus(16'h0400, 16'h0000, lat, q, err);
      checkOutput("zero_div_latency", lat, 1, 0);
      checkOutput("zero_div_q", q, 0, 0);
      checkOutput("zero_div_err", err, 1, 0);

      // Consumer stalls: result must hold and new offers must be ignored.
      out_ready = 1'b0;
      applyStimulus(16'h1000, 16'h2000, lat, q, err);
      checkOutput("stall_q", q, 2048, 2);
      q0 = q;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         y_in = 16'h7000;
         x_in = (c % 2 == 0) ? 16'h1000 : 16'h0000;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         checkOutput("stall_q_stable", int'($signed(q_out)), q0, 0);
         checkOutput("stall_in_ready", int'(in_ready), 0, 0);
         checkOutput("stall_out_valid", int'(out_valid), 1, 0);
         checkOutput("stall_div_err", int'(div_err), 0, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("release_in_ready", int'(in_ready), 1, 0);
      checkOutput("release_out_valid", int'(out_valid), 0, 0);

      // Abort a division during iteration 5 with an asynchronous reset.
      @(negedge clk);
      y_in = 16'h0800;
      x_in = 16'h1000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_in_ready", int'(in_ready), 1, 0);
      checkOutput("abort_out_valid", int'(out_valid), 0, 0);
      checkOutput("abort_q_out", int'(q_out), 0, 0);
      checkOutput("abort_div_err", int'(div_err), 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      checkOutput("abort_no_residual", seen, 0, 0);
      applyStimulus(16'h0800, 16'h1000, lat, q, err);
      checkOutput("after_abort_q", q, 2048, 2);
      checkOutput("after_abort_latency", lat, ITER + 1, 0);

      // Sweep with divisors whose shifted copies stay exact, so the reference
      // is simply the truncated real quotient.
      for (int n = 0; n < 150; n++) begin
         kv = int'($urandom_range(1, 7));
         xs = ($urandom_range(0, 1) == 0) ? kv * 4096 : -kv * 4096;
         lim = (2 * kv * 4096) - 1;
         if (lim > 32767) lim = 32767;
         ys = int'($urandom_range(0, 2 * lim)) - lim;
         expq = (ys * 4096) / xs;
         applyStimulus(16'(ys), 16'(xs), lat, q, err);
         checkOutput("sweep_q", q, expq, 2);
         checkOutput("sweep_latency", lat, ITER + 1, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
      $finish;
   end

endmodule
